// File: rtl/xor_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor_seq_pkg
// Description : Shared types and constants for the xor_parity_arbiter block.
// Revision    : 1.0 - initial release
// ============================================================================
package xor_seq_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic REQ0       = 1'b0;
   localparam logic REQ1       = 1'b1;
   // Last-served pointer starts at requester 1, so requester 0 wins the first tie.
   localparam logic LAST_RESET = REQ1;

endpackage
`default_nettype wire

// File: rtl/xor3_cell.sv
`default_nettype none
// ============================================================================
// Module      : xor3_cell
// Description : Single 3-input XOR cell shared by the parity sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module xor3_cell (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic F
);

   assign F = A ^ B ^ C;

endmodule
`default_nettype wire

// File: rtl/xor_parity_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xor_parity_arbiter
// Description : Two-requester round-robin front end feeding a 2-bit-per-cycle
//               serial parity engine built around one xor3_cell.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_parity_arbiter
   import xor_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Req0,
   input  logic [WIDTH-1:0] Data0,
   input  logic             Odd0,
   input  logic             Req1,
   input  logic [WIDTH-1:0] Data1,
   input  logic             Odd1,
   output logic             Gnt0,
   output logic             Gnt1,
   output logic             Busy,
   output logic             Parity,
   output logic             Owner,
   output logic             Done
);

   localparam int                N          = (WIDTH + 1) / 2;
   localparam int                CNT_W      = $clog2(N + 1);
   localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(N - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_shift;
   logic             r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_last;
   logic             r_owner_lat;
   logic             w_winner;
   logic             w_accept;
   logic             w_run_end;
   logic             w_xor;

   xor3_cell u_xor3 (
      .A (r_acc),
      .B (r_shift[0]),
      .C (r_shift[1]),
      .F (w_xor)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A lone requester always wins; on a tie the one not served last wins.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_run_end    = 1'b0;
      w_winner     = (Req0 && Req1) ? ~r_last : Req1;
      case (r_state)
         IDLE: begin
            if (Req0 || Req1) begin
               w_accept     = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (r_cnt == c_cnt_last) begin
               w_run_end    = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Gnt0        <= 1'b0;
         Gnt1        <= 1'b0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         Parity      <= 1'b0;
         Owner       <= 1'b0;
         r_last      <= LAST_RESET;
         r_owner_lat <= REQ0;
         r_shift     <= '0;
         r_acc       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         Gnt0 <= 1'b0;
         Gnt1 <= 1'b0;
         Done <= 1'b0;
         if (w_accept) begin
            r_shift     <= (w_winner == REQ1) ? Data1 : Data0;
            r_acc       <= (w_winner == REQ1) ? Odd1 : Odd0;
            r_cnt       <= '0;
            r_owner_lat <= w_winner;
            r_last      <= w_winner;
            Gnt0        <= (w_winner == REQ0);
            Gnt1        <= (w_winner == REQ1);
            Busy        <= 1'b1;
         end else if (r_state == RUN) begin
            // Zero fill keeps the padding bit of an odd WIDTH out of the result.
            r_acc   <= w_xor;
            r_shift <= r_shift >> 2;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_run_end) begin
               Parity <= w_xor;
               Owner  <= r_owner_lat;
               Done   <= 1'b1;
               Busy   <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_xor_parity_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_parity_arbiter
// Description : Directed self-checking bench for xor_parity_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_parity_arbiter;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Req0 = 1'b0, Req1 = 1'b0, Odd0 = 1'b0, Odd1 = 1'b0;
   logic [7:0] Data0 = '0, Data1 = '0;
   logic       Gnt0, Gnt1, Busy, Parity, Owner, Done;

   logic       r5_req0 = 1'b0, r5_req1 = 1'b0, r5_odd0 = 1'b0, r5_odd1 = 1'b0;
   logic [4:0] r5_data0 = '0, r5_data1 = '0;
   logic       r5_gnt0, r5_gnt1, r5_busy, r5_parity, r5_owner, r5_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   xor_parity_arbiter #(.WIDTH(8)) u_dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .Req0(Req0), .Data0(Data0), .Odd0(Odd0),
      .Req1(Req1), .Data1(Data1), .Odd1(Odd1),
      .Gnt0(Gnt0), .Gnt1(Gnt1), .Busy(Busy),
      .Parity(Parity), .Owner(Owner), .Done(Done)
   );

   xor_parity_arbiter #(.WIDTH(5)) u_dut5 (
      .Clk(Clk), .Reset_n(Reset_n),
      .Req0(r5_req0), .Data0(r5_data0), .Odd0(r5_odd0),
      .Req1(r5_req1), .Data1(r5_data1), .Odd1(r5_odd1),
      .Gnt0(r5_gnt0), .Gnt1(r5_gnt1), .Busy(r5_busy),
      .Parity(r5_parity), .Owner(r5_owner), .Done(r5_done)
   );

   task automatic do_reset();
      Req0 = 1'b0; Req1 = 1'b0;
      Reset_n = 1'b0;
      @(negedge Clk); @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      @(negedge Clk);
      checks++;
      if ({Gnt0, Gnt1, Busy, Done, Parity, Owner} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 000000", {Gnt0, Gnt1, Busy, Done, Parity, Owner});
      end
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_single_word(input logic odd, input logic exp_par);
      int t;
      Data0 = 8'hA5; Odd0 = odd; Req0 = 1'b1;
      t = 0;
      do begin @(negedge Clk); t++; end while (!Gnt0 && t < 20);
      checks++;
      if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0 || Busy !== 1'b1 || Done !== 1'b0) begin
         errors++;
         $display("FAIL single_accept: gnt0=%b gnt1=%b busy=%b done=%b required 1 0 1 0", Gnt0, Gnt1, Busy, Done);
      end
      Req0 = 1'b0; Data0 = 8'h00; Odd0 = ~odd;
      for (int i = 1; i < 4; i++) begin
         @(negedge Clk);
         checks++;
         if (Done !== 1'b0 || Gnt0 !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL single_run%0d: done=%b gnt0=%b busy=%b required 0 0 1", i, Done, Gnt0, Busy);
         end
      end
      @(negedge Clk);
      checks++;
      if ({Done, Parity, Owner, Busy} !== {1'b1, exp_par, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL single_done: done/par/own/busy=%b required %b", {Done, Parity, Owner, Busy}, {1'b1, exp_par, 2'b00});
      end
      @(negedge Clk);
      checks++;
      if (Done !== 1'b0 || Parity !== exp_par) begin
         errors++;
         $display("FAIL single_hold: done=%b parity=%b required 0 %b", Done, Parity, exp_par);
      end
   endtask

   task automatic test_arbitration();
      int t;
      do_reset();
      Data0 = 8'h07; Odd0 = 1'b0; Data1 = 8'hFF; Odd1 = 1'b1;
      Req0 = 1'b1; Req1 = 1'b1;
      t = 0;
      do begin @(negedge Clk); t++; end while (!(Gnt0 || Gnt1) && t < 20);
      checks++;
      if ({Gnt0, Gnt1} !== 2'b10) begin
         errors++;
         $display("FAIL arb_first: gnt0/gnt1=%b required 10", {Gnt0, Gnt1});
      end
      Req0 = 1'b0;
      for (int i = 1; i < 4; i++) begin
         @(negedge Clk);
         checks++;
         if (Gnt1 !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL arb_wait%0d: gnt1=%b done=%b required 0 0", i, Gnt1, Done);
         end
      end
      @(negedge Clk);
      checks++;
      if ({Done, Parity, Owner, Gnt1} !== 4'b1100) begin
         errors++;
         $display("FAIL arb_done0: done/par/own/gnt1=%b required 1100", {Done, Parity, Owner, Gnt1});
      end
      @(negedge Clk);
      checks++;
      if ({Gnt1, Gnt0, Done, Busy} !== 4'b1001) begin
         errors++;
         $display("FAIL arb_gnt1: gnt1/gnt0/done/busy=%b required 1001", {Gnt1, Gnt0, Done, Busy});
      end
      Req1 = 1'b0;
      repeat (4) @(negedge Clk);
      checks++;
      if ({Done, Parity, Owner} !== 3'b111) begin
         errors++;
         $display("FAIL arb_done1: done/par/own=%b required 111", {Done, Parity, Owner});
      end
   endtask

   task automatic test_req_during_run();
      int t;
      Data0 = 8'h81; Odd0 = 1'b0; Req0 = 1'b1;
      t = 0;
      do begin @(negedge Clk); t++; end while (!Gnt0 && t < 20);
      Req0 = 1'b0;
      @(negedge Clk);
      Data1 = 8'h01; Odd1 = 1'b0; Req1 = 1'b1;
      for (int i = 2; i < 4; i++) begin
         @(negedge Clk);
         checks++;
         if (Gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL late_req_nogrant%0d: gnt1=%b required 0", i, Gnt1);
         end
      end
      @(negedge Clk);
      checks++;
      if ({Done, Parity, Owner, Gnt1} !== 4'b1000) begin
         errors++;
         $display("FAIL late_req_done0: done/par/own/gnt1=%b required 1000", {Done, Parity, Owner, Gnt1});
      end
      @(negedge Clk);
      checks++;
      if (Gnt1 !== 1'b1) begin
         errors++;
         $display("FAIL late_req_gnt1: gnt1=%b required 1", Gnt1);
      end
      Req1 = 1'b0;
      repeat (4) @(negedge Clk);
      checks++;
      if ({Done, Parity, Owner} !== 3'b111) begin
         errors++;
         $display("FAIL late_req_done1: done/par/own=%b required 111", {Done, Parity, Owner});
      end
   endtask

   task automatic test_reset_mid_run();
      int  t;
      logic seen_done;
      Data0 = 8'hFF; Odd0 = 1'b0; Req0 = 1'b1;
      t = 0;
      do begin @(negedge Clk); t++; end while (!Gnt0 && t < 20);
      Req0 = 1'b0;
      @(posedge Clk); @(posedge Clk);
      #1 Reset_n = 1'b0;
      #1;
      checks++;
      if ({Busy, Done, Gnt0, Gnt1, Parity, Owner} !== 6'b0) begin
         errors++;
         $display("FAIL midrun_reset: busy/done/g0/g1/par/own=%b required 000000", {Busy, Done, Gnt0, Gnt1, Parity, Owner});
      end
      @(negedge Clk); @(negedge Clk);
      Reset_n = 1'b1;
      seen_done = 1'b0;
      repeat (8) begin
         @(negedge Clk);
         if (Done) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin
         errors++;
         $display("FAIL midrun_no_done: done seen=%b required 0", seen_done);
      end
      Data0 = 8'h3C; Odd0 = 1'b1; Req0 = 1'b1;
      t = 0;
      do begin @(negedge Clk); t++; end while (!Gnt0 && t < 20);
      Req0 = 1'b0;
      repeat (4) @(negedge Clk);
      checks++;
      if ({Done, Parity, Owner} !== 3'b110) begin
         errors++;
         $display("FAIL midrun_recover: done/par/own=%b required 110", {Done, Parity, Owner});
      end
   endtask

   task automatic test_width5();
      logic [4:0] vec [2];
      logic       odd [2];
      logic       expv[2];
      int         t;
      vec[0] = 5'b10101; odd[0] = 1'b0; expv[0] = 1'b1;
      vec[1] = 5'b10000; odd[1] = 1'b1; expv[1] = 1'b0;
      for (int w = 0; w < 2; w++) begin
         r5_data0 = vec[w]; r5_odd0 = odd[w]; r5_req0 = 1'b1;
         t = 0;
         do begin @(negedge Clk); t++; end while (!r5_gnt0 && t < 20);
         r5_req0 = 1'b0;
         for (int i = 1; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (r5_done !== 1'b0 || r5_busy !== 1'b1) begin
               errors++;
               $display("FAIL w5_run%0d_%0d: done=%b busy=%b required 0 1", w, i, r5_done, r5_busy);
            end
         end
         @(negedge Clk);
         checks++;
         if ({r5_done, r5_parity, r5_owner} !== {1'b1, expv[w], 1'b0}) begin
            errors++;
            $display("FAIL w5_done%0d: done/par/own=%b required %b", w, {r5_done, r5_parity, r5_owner}, {1'b1, expv[w], 1'b0});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d0, d1;
      logic       o0, o1, exp_par, exp_own;
      int         t, last_cyc;
      do_reset();
      d0 = 8'h5A; o0 = 1'b0; d1 = 8'hC3; o1 = 1'b1;
      Data0 = d0; Odd0 = o0; Data1 = d1; Odd1 = o1;
      Req0 = 1'b1; Req1 = 1'b1;
      last_cyc = 0;
      for (int w = 0; w < 10; w++) begin
         t = 0;
         do begin @(negedge Clk); t++; end while (!(Gnt0 || Gnt1) && t < 20);
         checks++;
         if ({Gnt0, Gnt1} !== ((w % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL b2b_order%0d: gnt0/gnt1=%b required %b", w, {Gnt0, Gnt1}, (w % 2 == 0) ? 2'b10 : 2'b01);
         end
         if (w > 0) begin
            checks++;
            if (cyc - last_cyc != 5) begin
               errors++;
               $display("FAIL b2b_spacing%0d: got %0d cycles required 5", w, cyc - last_cyc);
            end
         end
         last_cyc = cyc;
         exp_own = Gnt1;
         if (Gnt1) begin
            exp_par = (^d1) ^ o1;
            d1 = d1 * 8'd13 + 8'h1F; o1 = ~o1;
            Data1 = d1; Odd1 = o1;
         end else begin
            exp_par = (^d0) ^ o0;
            d0 = d0 * 8'd7 + 8'h35; o0 = ~o0;
            Data0 = d0; Odd0 = o0;
         end
         t = 0;
         do begin @(negedge Clk); t++; end while (!Done && t < 20);
         checks++;
         if ({Done, Parity, Owner} !== {1'b1, exp_par, exp_own}) begin
            errors++;
            $display("FAIL b2b_result%0d: done/par/own=%b required %b", w, {Done, Parity, Owner}, {1'b1, exp_par, exp_own});
         end
      end
      Req0 = 1'b0; Req1 = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(negedge Clk);
      test_reset();
      test_single_word(1'b0, 1'b0);
      test_single_word(1'b1, 1'b1);
      test_arbitration();
      test_req_during_run();
      test_reset_mid_run();
      test_width5();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
